// File: rtl/alarm_if.sv
// alarm_if: clock-time inputs, buttons and alarm outputs of alarm_controller.
// The controller uses the slave modport; the clock/button side uses master.
interface alarm_if;
    logic       tick_1Hz;
    logic [3:0] sec_1s;
    logic [3:0] sec_10s;
    logic [3:0] min_1s;
    logic [3:0] min_10s;
    logic [3:0] hr_1s;
    logic [3:0] hr_10s;
    logic       am_pm;
    logic       alarm_en;
    logic       set_hr;
    logic       set_min;
    logic       set_am_pm;
    logic       stop;
    logic       snooze;
    logic [3:0] alarm_hr_10s;
    logic [3:0] alarm_hr_1s;
    logic [3:0] alarm_min_10s;
    logic [3:0] alarm_min_1s;
    logic       alarm_am_pm;
    logic       ringing;
    logic       snoozed;
    logic       buzzer;

    modport master (
        output tick_1Hz, sec_1s, sec_10s, min_1s, min_10s,
        output hr_1s, hr_10s, am_pm, alarm_en,
        output set_hr, set_min, set_am_pm, stop, snooze,
        input  alarm_hr_10s, alarm_hr_1s, alarm_min_10s, alarm_min_1s,
        input  alarm_am_pm, ringing, snoozed, buzzer
    );

    modport slave (
        input  tick_1Hz, sec_1s, sec_10s, min_1s, min_10s,
        input  hr_1s, hr_10s, am_pm, alarm_en,
        input  set_hr, set_min, set_am_pm, stop, snooze,
        output alarm_hr_10s, alarm_hr_1s, alarm_min_10s, alarm_min_1s,
        output alarm_am_pm, ringing, snoozed, buzzer
    );
endinterface

// File: rtl/alarm_controller.sv
// alarm_controller: alarm time, match, ring/stop/snooze/timeout and buzzer.
// Optional snooze support is enabled by defining ALARM_SNOOZE_EN.
module alarm_controller #(
    parameter int SNOOZE_MIN     = 9,
    parameter int RING_TIMEOUT_S = 60,
    parameter int BEEP_DIV       = 12_500_000
) (
    input logic   clk_50MHz,
    input logic   reset,
    alarm_if.slave bus
);

`ifdef ALARM_SNOOZE_EN
    typedef enum logic [1:0] {IDLE, ARMED, RINGING, SNOOZE} state_t;
`else
    typedef enum logic [1:0] {IDLE, ARMED, RINGING} state_t;
`endif

    localparam int BW = (BEEP_DIV > 1) ? $clog2(BEEP_DIV) : 1;

    state_t     state, state_n;
    logic [2:0] tick_s, hr_s, min_s, ap_s, stop_s;
    logic [1:0] en_s;
    logic       en, tick_p, hr_p, min_p, ap_p, stop_p;
    logic [3:0] alarm_hr;
    logic [5:0] alarm_min;
    logic       alarm_ap;
    logic [7:0] ring_ctr, ring_n;
    logic [BW-1:0] beep_ctr;
    logic       buzz;
    logic [7:0] clk_hr, clk_min;
    logic       match;
    logic [5:0] m10, m1;

`ifdef ALARM_SNOOZE_EN
    logic [2:0]  snz_s;
    logic        snz_p;
    logic [11:0] snz_ctr, snz_n;
`else
    wire unused_snz = bus.snooze;
    localparam int snz_min_unused = SNOOZE_MIN;
`endif

    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) begin
            tick_s <= '0;
            hr_s   <= '0;
            min_s  <= '0;
            ap_s   <= '0;
            stop_s <= '0;
            en_s   <= '0;
        end else begin
            tick_s <= {tick_s[1:0], bus.tick_1Hz};
            hr_s   <= {hr_s[1:0], bus.set_hr};
            min_s  <= {min_s[1:0], bus.set_min};
            ap_s   <= {ap_s[1:0], bus.set_am_pm};
            stop_s <= {stop_s[1:0], bus.stop};
            en_s   <= {en_s[0], bus.alarm_en};
        end
    end

    assign tick_p = tick_s[1] & ~tick_s[2];
    assign hr_p   = hr_s[1] & ~hr_s[2];
    assign min_p  = min_s[1] & ~min_s[2];
    assign ap_p   = ap_s[1] & ~ap_s[2];
    assign stop_p = stop_s[1] & ~stop_s[2];
    assign en     = en_s[1];

`ifdef ALARM_SNOOZE_EN
    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) snz_s <= '0;
        else        snz_s <= {snz_s[1:0], bus.snooze};
    end

    assign snz_p = snz_s[1] & ~snz_s[2];
`endif

    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) begin
            alarm_hr  <= 4'd12;
            alarm_min <= 6'd0;
            alarm_ap  <= 1'b0;
        end else if (state == IDLE) begin
            if (hr_p)
                alarm_hr <= (alarm_hr == 4'd12) ? 4'd1 : alarm_hr + 4'd1;
            if (min_p)
                alarm_min <= (alarm_min == 6'd59) ? 6'd0 : alarm_min + 6'd1;
            if (ap_p)
                alarm_ap <= ~alarm_ap;
        end
    end

    assign m10 = alarm_min / 6'd10;
    assign m1  = alarm_min % 6'd10;

    assign bus.alarm_hr_10s  = (alarm_hr >= 4'd10) ? 4'd1 : 4'd0;
    assign bus.alarm_hr_1s   = (alarm_hr >= 4'd10) ? alarm_hr - 4'd10
                                                   : alarm_hr;
    assign bus.alarm_min_10s = m10[3:0];
    assign bus.alarm_min_1s  = m1[3:0];
    assign bus.alarm_am_pm   = alarm_ap;

    assign clk_hr  = {4'd0, bus.hr_10s} * 8'd10 + {4'd0, bus.hr_1s};
    assign clk_min = {4'd0, bus.min_10s} * 8'd10 + {4'd0, bus.min_1s};

    assign match = (clk_hr == {4'd0, alarm_hr})
                && (clk_min == {2'd0, alarm_min})
                && (bus.sec_10s == 4'd0)
                && (bus.sec_1s == 4'd0)
                && (bus.am_pm == alarm_ap);

    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            ring_ctr <= '0;
        end else begin
            state    <= state_n;
            ring_ctr <= ring_n;
        end
    end

`ifdef ALARM_SNOOZE_EN
    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) snz_ctr <= '0;
        else        snz_ctr <= snz_n;
    end
`endif

    always_comb begin
        state_n = state;
        ring_n  = ring_ctr;
`ifdef ALARM_SNOOZE_EN
        snz_n   = snz_ctr;
`endif
        unique case (state)
            IDLE: begin
                if (en) state_n = ARMED;
            end
            ARMED: begin
                if (!en) begin
                    state_n = IDLE;
                end else if (tick_p && match) begin
                    state_n = RINGING;
                    ring_n  = '0;
                end
            end
            RINGING: begin
                if (!en) begin
                    state_n = IDLE;
                end else if (stop_p) begin
                    state_n = ARMED;
`ifdef ALARM_SNOOZE_EN
                end else if (snz_p) begin
                    state_n = SNOOZE;
                    snz_n   = 12'(SNOOZE_MIN * 60);
`endif
                end else if (tick_p) begin
                    if (ring_ctr == 8'(RING_TIMEOUT_S - 1))
                        state_n = ARMED;
                    else
                        ring_n = ring_ctr + 8'd1;
                end
            end
`ifdef ALARM_SNOOZE_EN
            SNOOZE: begin
                if (!en) begin
                    state_n = IDLE;
                end else if (stop_p) begin
                    state_n = ARMED;
                end else if (tick_p) begin
                    if (snz_ctr == 12'd1) begin
                        state_n = RINGING;
                        ring_n  = '0;
                    end else begin
                        snz_n = snz_ctr - 12'd1;
                    end
                end
            end
`endif
            default: state_n = IDLE;
        endcase
    end

    // buzzer restarts high on every entry into RINGING
    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) begin
            buzz     <= 1'b0;
            beep_ctr <= '0;
        end else if (state_n != RINGING) begin
            buzz     <= 1'b0;
            beep_ctr <= '0;
        end else if (state != RINGING) begin
            buzz     <= 1'b1;
            beep_ctr <= '0;
        end else if (beep_ctr == BW'(BEEP_DIV - 1)) begin
            buzz     <= ~buzz;
            beep_ctr <= '0;
        end else begin
            beep_ctr <= beep_ctr + 1'b1;
        end
    end

    assign bus.buzzer  = buzz;
    assign bus.ringing = (state == RINGING);
`ifdef ALARM_SNOOZE_EN
    assign bus.snoozed = (state == SNOOZE);
`else
    assign bus.snoozed = 1'b0;
`endif

endmodule

// File: tb/tb_alarm_controller.sv
// tb_alarm_controller: directed checks of alarm_controller with
// BEEP_DIV=4, RING_TIMEOUT_S=5, SNOOZE_MIN=1.
module tb_alarm_controller;

    logic clk_50MHz;
    logic reset;
    int   total;
    int   passed;

    alarm_if ai ();

    alarm_controller #(
        .SNOOZE_MIN     (1),
        .RING_TIMEOUT_S (5),
        .BEEP_DIV       (4)
    ) dut (
        .clk_50MHz (clk_50MHz),
        .reset     (reset),
        .bus       (ai.slave)
    );

    initial clk_50MHz = 1'b0;
    always #10 clk_50MHz = ~clk_50MHz;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic chk_alarm(input string tag, input int h10, input int h1,
                             input int m10, input int m1, input int ap);
        chk({tag, "_h10"}, int'(ai.alarm_hr_10s), h10);
        chk({tag, "_h1"},  int'(ai.alarm_hr_1s), h1);
        chk({tag, "_m10"}, int'(ai.alarm_min_10s), m10);
        chk({tag, "_m1"},  int'(ai.alarm_min_1s), m1);
        chk({tag, "_ap"},  int'(ai.alarm_am_pm), ap);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk_50MHz);
        #1;
    endtask

    // 0 set_hr, 1 set_min, 2 set_am_pm, 3 stop, 4 snooze, 5 stop+snooze
    task automatic press(input int b);
        case (b)
            0: ai.set_hr = 1'b1;
            1: ai.set_min = 1'b1;
            2: ai.set_am_pm = 1'b1;
            3: ai.stop = 1'b1;
            4: ai.snooze = 1'b1;
            default: begin
                ai.stop   = 1'b1;
                ai.snooze = 1'b1;
            end
        endcase
        wait_cyc(1);
        ai.set_hr    = 1'b0;
        ai.set_min   = 1'b0;
        ai.set_am_pm = 1'b0;
        ai.stop      = 1'b0;
        ai.snooze    = 1'b0;
        wait_cyc(2);
    endtask

    task automatic set_time(input int h10, input int h1, input int m10,
                            input int m1, input int s10, input int s1,
                            input int ap);
        ai.hr_10s  = 4'(h10);
        ai.hr_1s   = 4'(h1);
        ai.min_10s = 4'(m10);
        ai.min_1s  = 4'(m1);
        ai.sec_10s = 4'(s10);
        ai.sec_1s  = 4'(s1);
        ai.am_pm   = 1'(ap);
    endtask

    task automatic tick();
        ai.tick_1Hz = 1'b1;
        wait_cyc(1);
        ai.tick_1Hz = 1'b0;
        wait_cyc(2);
    endtask

    initial begin
        total = 0;
        passed = 0;
        reset = 1'b0;
        ai.tick_1Hz  = 1'b0;
        ai.alarm_en  = 1'b0;
        ai.set_hr    = 1'b0;
        ai.set_min   = 1'b0;
        ai.set_am_pm = 1'b0;
        ai.stop      = 1'b0;
        ai.snooze    = 1'b0;
        set_time(0, 1, 0, 0, 0, 1, 0);
        wait_cyc(2);

        chk_alarm("rst", 1, 2, 0, 0, 0);
        chk("rst_ring", int'(ai.ringing), 0);
        chk("rst_snz", int'(ai.snoozed), 0);
        chk("rst_buz", int'(ai.buzzer), 0);
        reset = 1'b1;
        wait_cyc(2);

        repeat (3) press(0);
        repeat (61) press(1);
        press(2);
        chk_alarm("set_idle", 0, 3, 0, 1, 1);

        ai.alarm_en = 1'b1;
        wait_cyc(3);
        press(0);
        press(1);
        press(2);
        chk_alarm("set_armed", 0, 3, 0, 1, 1);

        ai.alarm_en = 1'b0;
        wait_cyc(3);
        repeat (3) press(0);
        repeat (29) press(1);
        press(2);
        chk_alarm("set_0630", 0, 6, 3, 0, 0);

        ai.alarm_en = 1'b1;
        wait_cyc(3);
        set_time(0, 6, 2, 9, 5, 9, 0);
        tick();
        chk("no_early", int'(ai.ringing), 0);

        set_time(0, 6, 3, 0, 0, 0, 0);
        ai.tick_1Hz = 1'b1;
        wait_cyc(1);
        ai.tick_1Hz = 1'b0;
        chk("ring_n0", int'(ai.ringing), 0);
        wait_cyc(1);
        chk("ring_n1", int'(ai.ringing), 0);
        wait_cyc(1);
        chk("ring_n2", int'(ai.ringing), 1);
        chk("buz_n2", int'(ai.buzzer), 1);
        wait_cyc(3);
        chk("buz_n5", int'(ai.buzzer), 1);
        wait_cyc(1);
        chk("buz_n6", int'(ai.buzzer), 0);
        wait_cyc(3);
        chk("buz_n9", int'(ai.buzzer), 0);
        wait_cyc(1);
        chk("buz_n10", int'(ai.buzzer), 1);

        press(3);
        chk("stop_ring", int'(ai.ringing), 0);
        chk("stop_buz", int'(ai.buzzer), 0);
        for (int s = 1; s <= 5; s++) begin
            set_time(0, 6, 3, 0, 0, s, 0);
            tick();
            chk("no_retrig", int'(ai.ringing), 0);
        end

        set_time(0, 6, 3, 0, 0, 0, 0);
        tick();
        chk("ring2", int'(ai.ringing), 1);
        press(5);
        chk("both_ring", int'(ai.ringing), 0);
        chk("both_snz", int'(ai.snoozed), 0);
        tick();
        chk("both_armed", int'(ai.ringing), 1);

`ifdef ALARM_SNOOZE_EN
        press(4);
        chk("snz_on", int'(ai.snoozed), 1);
        chk("snz_ring", int'(ai.ringing), 0);
        chk("snz_buz", int'(ai.buzzer), 0);
        set_time(0, 6, 3, 0, 0, 1, 0);
        repeat (59) tick();
        chk("snz59_snz", int'(ai.snoozed), 1);
        chk("snz59_ring", int'(ai.ringing), 0);
        tick();
        chk("snz60_ring", int'(ai.ringing), 1);
        chk("snz60_snz", int'(ai.snoozed), 0);
        press(4);
        chk("snz2_on", int'(ai.snoozed), 1);
        press(3);
        chk("snz_stop_snz", int'(ai.snoozed), 0);
        chk("snz_stop_ring", int'(ai.ringing), 0);
`else
        press(4);
        chk("nosnz_ring", int'(ai.ringing), 1);
        chk("nosnz_snz", int'(ai.snoozed), 0);
        press(3);
        chk("nosnz_stop", int'(ai.ringing), 0);
`endif

        set_time(0, 6, 3, 0, 0, 0, 0);
        tick();
        chk("ring3", int'(ai.ringing), 1);
        set_time(0, 6, 3, 0, 0, 1, 0);
        repeat (4) tick();
        chk("tmo4", int'(ai.ringing), 1);
        tick();
        chk("tmo5", int'(ai.ringing), 0);
        chk("tmo5_buz", int'(ai.buzzer), 0);

        set_time(0, 6, 3, 0, 0, 0, 0);
        tick();
        chk("ring4", int'(ai.ringing), 1);
        ai.alarm_en = 1'b0;
        wait_cyc(2);
        chk("en_n1", int'(ai.ringing), 1);
        wait_cyc(1);
        chk("en_off_ring", int'(ai.ringing), 0);
        chk("en_off_buz", int'(ai.buzzer), 0);
        chk("en_off_snz", int'(ai.snoozed), 0);
        press(0);
        chk_alarm("idle_set", 0, 7, 3, 0, 0);

        ai.alarm_en = 1'b1;
        wait_cyc(3);
        set_time(0, 7, 3, 0, 0, 0, 0);
        tick();
        chk("ring5", int'(ai.ringing), 1);
        reset = 1'b0;
        #1;
        chk_alarm("mid_rst", 1, 2, 0, 0, 0);
        chk("mid_rst_ring", int'(ai.ringing), 0);
        chk("mid_rst_buz", int'(ai.buzzer), 0);
        chk("mid_rst_snz", int'(ai.snoozed), 0);
        ai.alarm_en = 1'b0;
        wait_cyc(2);
        reset = 1'b1;
        wait_cyc(2);
        press(0);
        chk_alarm("post_rst", 0, 1, 0, 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/alarm_controller.md
# alarm_controller

Alarm stage directly downstream of the 12-hour binary clock. It consumes the clock's BCD time digits, AM/PM flag and 1 Hz square wave. It holds a user-set alarm time and raises a ringing/buzzer output when the clock reaches that time, with stop, snooze and auto-timeout. Its alarm-time BCD outputs feed the display mux alongside the clock digits.

## Interface
- SNOOZE_MIN, 9: snooze length in minutes (1..59).
- RING_TIMEOUT_S, 60: seconds of ringing before auto-stop (1..255).
- BEEP_DIV, 12_500_000: clk cycles per buzzer half-period.

- clk_50MHz  in  1  system clock
- reset  in  1  asynchronous, active-low
- tick_1Hz  in  1  clock's 1 Hz square wave (rising edge = clock second update)
- sec_1s, sec_10s, min_1s, min_10s, hr_1s, hr_10s  in  4 each  clock BCD time
- am_pm  in  1  clock AM(0)/PM(1)
- alarm_en  in  1  level switch, alarm armed when 1
- set_hr, set_min, set_am_pm  in  1  raw buttons, adjust alarm time
- stop, snooze  in  1  raw buttons
- alarm_hr_10s, alarm_hr_1s, alarm_min_10s, alarm_min_1s  out  4 each  alarm time BCD
- alarm_am_pm  out  1  alarm AM/PM
- ringing  out  1  high in RINGING
- snoozed  out  1  high in SNOOZE
- buzzer  out  1  beep waveform, 0 unless RINGING

## Operation
- Reset values:
  - alarm hours = 12, minutes = 0, am_pm = 0, so the alarm outputs read 1,2,0,0,0.
  - State = IDLE.
  - ringing, snoozed and buzzer = 0.
  - All counters = 0.
- Input conditioning:
  - tick_1Hz, set_*, stop and snooze each pass through a 3-FF synchroniser.
  - Each rising edge produces a 1-cycle pulse: pulse = s2 & ~s3.
- Alarm registers:
  - Held in binary: hours 4b, minutes 6b. BCD outputs are /10 and %10.
  - set_* pulses are accepted only in IDLE and ignored otherwise.
  - set_hr: 12→1, otherwise +1.
  - set_min: 59→0, otherwise +1, with no carry into hours.
  - set_am_pm: toggles.
- Match condition:
  - Clock hours (hr_10s*10+hr_1s) equal alarm hours.
  - Clock minutes equal alarm minutes.
  - sec_10s = sec_1s = 0.
  - am_pm equals alarm_am_pm.
  - Evaluated only in the tick pulse cycle.
- FSM states and transitions:
  - IDLE: alarm_en=1 → ARMED.
  - ARMED:
    - alarm_en=0 → IDLE.
    - tick pulse & match → RINGING; ring_ctr cleared.
  - RINGING:
    - ring_ctr increments on each tick pulse.
    - Priority: alarm_en=0 → IDLE > stop → ARMED > snooze → SNOOZE (snooze_ctr loaded with SNOOZE_MIN*60) > tick pulse with ring_ctr = RING_TIMEOUT_S-1 → ARMED.
  - SNOOZE:
    - Priority: alarm_en=0 → IDLE > stop → ARMED.
    - Each tick pulse decrements snooze_ctr. A tick pulse with snooze_ctr = 1 → RINGING, ring_ctr cleared.
    - Snooze pulses are ignored.
- Buzzer:
  - On entry to RINGING, buzzer is set to 1 and beep_ctr is cleared.
  - buzzer toggles each time beep_ctr wraps at BEEP_DIV-1.
  - Outside RINGING, buzzer = 0 and beep_ctr = 0.
- No re-trigger after stop or timeout in the same match second: the next tick carries sec ≠ 0.
- Simultaneous stop+snooze: stop wins.
- Reset mid-ring: immediately returns to the reset values. The alarm time is also reset.

## Timing
- All outputs are registered.
- A button or tick edge first sampled high at clk edge N produces its pulse between edges N+1 and N+2. The state change, ringing/snoozed and first buzzer=1 appear after edge N+2.
- Clock digits are stable 3 edges after the tick_1Hz rising edge, because the clock updates on that edge. Comparing in the tick pulse cycle therefore sees the new time.
- set_* pulses update the alarm outputs after edge N+2.
- alarm_en is a slow level, synchronised with 2 FFs. Deassertion takes effect after edge N+2.

## Configuration
- ALARM_SNOOZE_EN defined:
  - SNOOZE state, snooze_ctr and the snooze input path are present as above.
- ALARM_SNOOZE_EN undefined:
  - No SNOOZE state or snooze counter.
  - snooze is ignored, so RINGING exits only via alarm_en, stop or timeout.
  - snoozed is tied to 0 and SNOOZE_MIN is unused.

## Test plan
- Reset asserted mid-operation: alarm outputs read 1,2,0,0 and AM; ringing = snoozed = buzzer = 0; state IDLE.
- alarm_en=0 with 3 set_hr, 61 set_min and 1 set_am_pm pulses: alarm reads 03:01 PM. The same pulses with alarm_en=1 leave it unchanged.
- Alarm 06:30 AM, alarm_en=1, BEEP_DIV=4: clock steps 06:29:59 → 06:30:00 AM on a tick. ringing=1 three edges after the tick edge, and buzzer toggles every 4 cycles.
- Ringing, then stop pulse: ringing=0 and the state returns to ARMED. Ticks at 06:30:01..06:30:05 give no re-ring. Stop+snooze pressed together gives ARMED.
- With snooze enabled, SNOOZE_MIN=1: snooze pulse while ringing gives snoozed=1 and ringing=0. After the 60th tick pulse, ringing=1. Stop during SNOOZE gives ARMED.
- RING_TIMEOUT_S=5 with no buttons: ringing falls after the 5th tick pulse. alarm_en dropped mid-ring gives IDLE and all outputs 0. Built without ALARM_SNOOZE_EN, a snooze pulse leaves ringing=1.
